mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width of the shared memory.
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, the number of consecutive lost fetch arbitrations before fetch is forced a grant.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port if_req, input, 1, instruction-fetch request.
REQ-006 SHALL have port if_addr, input, ADDR_W, fetch byte address.
REQ-007 SHALL have port if_ready, output, 1, fetch response valid.
REQ-008 SHALL have port if_rdata, output, 32, fetched instruction.
REQ-009 SHALL have ports d_req (input, 1), d_we (input, 1), d_addr (input, ADDR_W), d_wdata (input, 32) and d_func3 (input, 3), the data-stage request, write enable, address, store data and access size.
REQ-010 SHALL have ports d_ready (output, 1) and d_rdata (output, 32), the data response valid and load data.
REQ-011 SHALL have ports mem_addr (output, ADDR_W), mem_wdata (output, 32), mem_func3 (output, 3), mem_re (output, 1) and mem_we (output, 1), driving the single shared memory.
REQ-012 SHALL have port mem_rdata, input, 32; memory read data, valid one cycle after mem_re.
REQ-013 SHALL have ports stall_if (output, 1) and stall_d (output, 1), pipeline stall requests.

Function
REQ-014 SHALL implement FSM states IDLE, RESP_IF and RESP_D.
REQ-015 In IDLE, SHALL grant combinationally to at most one requester, driving mem_* from that requester's inputs and asserting mem_re (read) or mem_we (write, d_we=1 only).
REQ-016 The grant SHALL move IDLE to RESP_IF (fetch) or RESP_D (data); with no request, the FSM SHALL stay in IDLE with mem_re=mem_we=0.
REQ-017 Data SHALL win when both requests are high, except under REQ-021.
REQ-018 RESP_IF SHALL assert if_ready=1 and if_rdata=mem_rdata; RESP_D SHALL assert d_ready=1 and d_rdata=mem_rdata, with d_rdata don't-care for writes.
REQ-019 Each RESP state SHALL return to IDLE unconditionally; request lines sampled during RESP SHALL be ignored. Latency is 2 cycles per access and throughput is 1 access per 2 cycles.
REQ-020 Requesters SHALL hold req and operands stable from assertion through their ready cycle inclusive; the arbiter SHALL NOT register operands.
REQ-021 A saturating starvation counter SHALL increment each IDLE cycle in which if_req=1 and data is granted; it SHALL clear on any fetch grant or when if_req=0; at count==STARVE_LIMIT, fetch SHALL win the next IDLE arbitration.
REQ-022 stall_if SHALL equal if_req AND NOT if_ready; stall_d SHALL equal d_req AND NOT d_ready (combinational).
REQ-023 Outside IDLE, mem_re and mem_we SHALL be 0, and if_ready/d_ready SHALL never both be 1.

Reset
REQ-024 On reset assertion, the FSM SHALL go to IDLE immediately and the starvation counter SHALL be set to 0.
REQ-025 While reset is high, mem_re, mem_we, if_ready and d_ready SHALL be 0, and if_rdata, d_rdata and mem_addr SHALL be 0.
REQ-026 Reset asserted during RESP SHALL abandon the access with no ready pulse; the requester re-requests.

Configuration
REQ-027 Macro MEMARB_STARVE_GUARD_EN SHALL gate the starvation guard: when defined, REQ-021 is active; when undefined, the counter is not built and data always wins (strict priority).

Verification
REQ-028 Bench: fetch only, if_req=1 with if_addr=0x10 and mem_rdata=0x00500093 -> if_ready=1 in cycle 2 with if_rdata=0x00500093, mem_re=1 in cycle 1 only.
REQ-029 Bench: if_req=1 and d_req=1 with d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF on the same cycle -> mem_we=1 with mem_addr=0x40 first, d_ready next cycle, then fetch granted; stall_if=1 for 3 cycles.
REQ-030 Bench: guard enabled, STARVE_LIMIT=3, both requests held high continuously -> grant sequence D,D,D,IF,D,D,D,IF; guard disabled -> fetch is never granted.
REQ-031 Bench: reset pulsed during RESP_D -> no d_ready pulse, FSM in IDLE, and with d_req=1 held the access is reissued on the first cycle after reset release.
REQ-032 Bench: load d_func3=3'b100, d_addr=0x03 -> mem_func3=3'b100, mem_addr=0x03, mem_re=1, and d_rdata=mem_rdata in the response cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the instruction-fetch stage and the
// data (load/store) stage. Each access takes two cycles: a grant cycle in IDLE,
// where the winner's operands are driven straight onto the memory port, and a
// response cycle (RESP_IF / RESP_D), where the memory read data is forwarded
// to the winner together with its ready strobe. Operands are never registered;
// requesters hold them stable until their ready cycle.
//
// Data wins a simultaneous request. With MEMARB_STARVE_GUARD_EN defined, a
// saturating counter tracks how many arbitrations in a row fetch has lost.
// Once it reaches STARVE_LIMIT, fetch wins the next arbitration. Without the
// macro, the counter is not built and data always has strict priority.
//
// Parameters
//   ADDR_W        byte-address width of the shared memory
//   STARVE_LIMIT  consecutive fetch losses before fetch is forced a grant
//
// Ports
//   clk, reset                  clock and asynchronous active-high reset
//   if_req, if_addr             fetch request and byte address
//   if_ready, if_rdata          fetch response strobe and instruction
//   d_req, d_we, d_addr,        data request, write enable, address,
//   d_wdata, d_func3            store data and access size
//   d_ready, d_rdata            data response strobe and load data
//   mem_addr, mem_wdata,        shared memory address, write data,
//   mem_func3, mem_re, mem_we   access size, read and write enables
//   mem_rdata                   memory read data, valid one cycle after mem_re
//   stall_if, stall_d           stall requests to the pipeline stages
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_func3,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_func3,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic              stall_if,
    output logic              stall_d
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic grant_if;
    logic grant_d;
    logic fetch_priority;

    // Arbitration: only in IDLE and never while reset is held.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if ((state == IDLE) && !reset) begin
            if (d_req && !(if_req && fetch_priority)) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end else begin
                grant_d  = 1'b0;
                grant_if = 1'b0;
            end
        end else begin
            grant_if = 1'b0;
            grant_d  = 1'b0;
        end
    end

`ifdef MEMARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign fetch_priority = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Starvation counter: counts fetch losses, clears once fetch is served or
    // stops asking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= starve_cnt;
        end
    end
`else
    assign fetch_priority = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: a grant opens a response cycle, which always closes.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = RESP_D;
                end else if (grant_if) begin
                    state_next = RESP_IF;
                end else begin
                    state_next = IDLE;
                end
            end
            RESP_IF: state_next = IDLE;
            RESP_D:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: memory port drive in IDLE, response forwarding in RESP_*.
    // Everything is forced low while reset is high, so a response cycle
    // caught by reset never produces a ready strobe.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
        mem_func3 = 3'b000;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        if_ready  = 1'b0;
        if_rdata  = 32'h0000_0000;
        d_ready   = 1'b0;
        d_rdata   = 32'h0000_0000;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                        mem_func3 = d_func3;
                        mem_re    = !d_we;
                        mem_we    = d_we;
                    end else if (grant_if) begin
                        // Instruction fetches are always full words.
                        mem_addr  = if_addr;
                        mem_func3 = 3'b010;
                        mem_re    = 1'b1;
                    end else begin
                        mem_re    = 1'b0;
                        mem_we    = 1'b0;
                    end
                end
                RESP_IF: begin
                    if_ready = 1'b1;
                    if_rdata = mem_rdata;
                end
                RESP_D: begin
                    d_ready = 1'b1;
                    d_rdata = mem_rdata;
                end
                default: begin
                    mem_re = 1'b0;
                    mem_we = 1'b0;
                end
            endcase
        end else begin
            mem_re = 1'b0;
            mem_we = 1'b0;
        end
    end

    assign stall_if = if_req & ~if_ready;
    assign stall_d  = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized run compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 8;
    localparam int LIMIT  = 3;
`ifdef MEMARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [2:0]        d_func3;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_func3;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    logic              stall_if;
    logic              stall_d;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_func3(mem_func3),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_d(stall_d)
    );

    always #5 clk = ~clk;

    task automatic go_idle();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 8'h55; d_addr = 8'h66; mem_rdata = 32'hA5A5_5A5A;
        @(negedge clk); #1;
        n_tests++;
        if ({mem_re, mem_we, if_ready, d_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes got=%b exp=0000", {mem_re, mem_we, if_ready, d_ready});
        end
        n_tests++;
        if (mem_addr !== 8'h00) begin
            n_fail++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr);
        end
        n_tests++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, d_rdata);
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; reset = 1'b0;
        #1;
        n_tests++;
        if ({mem_re, mem_we} !== 2'b00) begin
            n_fail++; $display("FAIL idle_no_req got=%b exp=00", {mem_re, mem_we});
        end
        go_idle();
    endtask

    task automatic test_fetch_only();
        @(negedge clk);
        if_req = 1'b1; if_addr = 8'h10; mem_rdata = 32'h0000_0000;
        #1;
        n_tests++;
        if ({mem_re, mem_we, mem_addr, if_ready, stall_if} !== {1'b1, 1'b0, 8'h10, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL fetch_c1 got re=%b we=%b addr=%h rdy=%b stall=%b exp 1 0 10 0 1",
                     mem_re, mem_we, mem_addr, if_ready, stall_if);
        end
        @(negedge clk);
        mem_rdata = 32'h0050_0093;
        #1;
        n_tests++;
        if ({if_ready, if_rdata, mem_re, stall_if} !== {1'b1, 32'h0050_0093, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_c2 got rdy=%b data=%h re=%b stall=%b exp 1 00500093 0 0",
                     if_ready, if_rdata, mem_re, stall_if);
        end
        go_idle();
    endtask

    task automatic test_contention();
        int stall_cycles = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 8'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 32'hDEAD_BEEF; d_func3 = 3'b010;
        #1;
        if (stall_if === 1'b1) stall_cycles++;
        n_tests++;
        if ({mem_we, mem_re, mem_addr, mem_wdata} !== {1'b1, 1'b0, 8'h40, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL cont_write got we=%b re=%b addr=%h wd=%h exp 1 0 40 deadbeef",
                     mem_we, mem_re, mem_addr, mem_wdata);
        end
        @(negedge clk); #1;
        if (stall_if === 1'b1) stall_cycles++;
        n_tests++;
        if ({d_ready, if_ready, mem_we, mem_re, stall_d} !== 5'b10000) begin
            n_fail++;
            $display("FAIL cont_dready got d=%b i=%b we=%b re=%b sd=%b exp 1 0 0 0 0",
                     d_ready, if_ready, mem_we, mem_re, stall_d);
        end
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        #1;
        if (stall_if === 1'b1) stall_cycles++;
        n_tests++;
        if ({mem_re, mem_addr} !== {1'b1, 8'h20}) begin
            n_fail++; $display("FAIL cont_fetch_grant got re=%b addr=%h exp 1 20", mem_re, mem_addr);
        end
        @(negedge clk);
        mem_rdata = 32'h1234_5678;
        #1;
        if (stall_if === 1'b1) stall_cycles++;
        n_tests++;
        if ({if_ready, if_rdata} !== {1'b1, 32'h1234_5678}) begin
            n_fail++; $display("FAIL cont_fetch_resp got rdy=%b data=%h exp 1 12345678", if_ready, if_rdata);
        end
        n_tests++;
        if (stall_cycles != 3) begin
            n_fail++; $display("FAIL cont_stall_if_cycles got=%0d exp=3", stall_cycles);
        end
        go_idle();
    endtask

    task automatic test_starvation();
        int exp_if;
        int fetch_grants = 0;
        int last_grant = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 8'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h80; d_func3 = 3'b010;
        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk);
            mem_rdata = $urandom;
            #1;
            if ((i % 2) == 0) begin
                // Every (LIMIT+1)-th grant goes to fetch when the guard is on.
                exp_if = (GUARD && (((i / 2) % (LIMIT + 1)) == LIMIT)) ? 1 : 0;
                last_grant = (mem_re && mem_addr == 8'h10) ? 1 : 0;
                if (last_grant == 1) fetch_grants++;
                n_tests++;
                if (!mem_re || (mem_addr !== (exp_if ? 8'h10 : 8'h80))) begin
                    n_fail++;
                    $display("FAIL starve_grant%0d got re=%b addr=%h exp addr=%h",
                             i / 2, mem_re, mem_addr, exp_if ? 8'h10 : 8'h80);
                end
            end else begin
                n_tests++;
                if ({if_ready, d_ready} !== (last_grant ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL starve_resp%0d got if/d=%b%b", i / 2, if_ready, d_ready);
                end
            end
        end
        n_tests++;
        if (fetch_grants != (GUARD ? 2 : 0)) begin
            n_fail++;
            $display("FAIL starve_fetch_count got=%0d exp=%0d", fetch_grants, GUARD ? 2 : 0);
        end
        go_idle();
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h33; d_func3 = 3'b010;
        #1;
        n_tests++;
        if ({mem_re, mem_addr} !== {1'b1, 8'h33}) begin
            n_fail++; $display("FAIL rst_resp_grant got re=%b addr=%h exp 1 33", mem_re, mem_addr);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({d_ready, mem_re, mem_we} !== 3'b000) begin
            n_fail++; $display("FAIL rst_resp_no_ready got d_ready/re/we=%b exp 000", {d_ready, mem_re, mem_we});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({d_ready, mem_re, mem_addr} !== {1'b0, 1'b1, 8'h33}) begin
            n_fail++;
            $display("FAIL rst_resp_reissue got rdy=%b re=%b addr=%h exp 0 1 33", d_ready, mem_re, mem_addr);
        end
        @(negedge clk);
        mem_rdata = 32'hCAFE_F00D;
        #1;
        n_tests++;
        if ({d_ready, d_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL rst_resp_done got rdy=%b data=%h exp 1 cafef00d", d_ready, d_rdata);
        end
        go_idle();
    endtask

    task automatic test_load_func3();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b100; d_addr = 8'h03;
        #1;
        n_tests++;
        if ({mem_func3, mem_addr, mem_re, mem_we} !== {3'b100, 8'h03, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL lbu_req got f3=%b addr=%h re=%b we=%b exp 100 03 1 0",
                     mem_func3, mem_addr, mem_re, mem_we);
        end
        @(negedge clk);
        mem_rdata = 32'h0000_00E7;
        #1;
        n_tests++;
        if ({d_ready, d_rdata} !== {1'b1, 32'h0000_00E7}) begin
            n_fail++; $display("FAIL lbu_resp got rdy=%b data=%h exp 1 000000e7", d_ready, d_rdata);
        end
        go_idle();
    endtask

    // Randomized run. The model works per transaction: each requester is
    // either waiting or idle, an access owns the port for two cycles, and
    // fetch overrides data once it has lost LIMIT arbitrations in a row.
    task automatic test_random();
        bit        if_act = 1'b0;
        bit        d_act  = 1'b0;
        int        owner  = 0;   // whose response is due this cycle (0 none, 1 fetch, 2 data)
        int        lost   = 0;   // consecutive fetch losses
        int        winner;
        bit        e_re, e_we, e_ir, e_dr;
        logic [7:0] e_addr;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (!if_act && ($urandom_range(0, 3) != 0)) begin
                if_act = 1'b1; if_addr = 8'($urandom);
            end
            if (!d_act && ($urandom_range(0, 2) != 0)) begin
                d_act = 1'b1; d_addr = 8'($urandom); d_we = 1'($urandom);
                d_wdata = $urandom; d_func3 = 3'($urandom);
            end
            if_req = if_act; d_req = d_act;
            mem_rdata = $urandom;
            #1;
            winner = 0;
            if (owner == 0) begin
                if (if_act && d_act) winner = (GUARD && lost >= LIMIT) ? 1 : 2;
                else if (d_act)      winner = 2;
                else if (if_act)     winner = 1;
                else                 winner = 0;
            end
            e_re   = (winner == 1) || (winner == 2 && !d_we);
            e_we   = (winner == 2 && d_we);
            e_addr = (winner == 1) ? if_addr : ((winner == 2) ? d_addr : 8'h00);
            e_ir   = (owner == 1);
            e_dr   = (owner == 2);
            n_tests++;
            if ({mem_re, mem_we, mem_addr} !== {e_re, e_we, e_addr}) begin
                n_fail++;
                $display("FAIL rand_mem cyc=%0d got re=%b we=%b addr=%h exp %b %b %h",
                         cyc, mem_re, mem_we, mem_addr, e_re, e_we, e_addr);
            end
            if (winner == 2) begin
                n_tests++;
                if ((mem_func3 !== d_func3) || (d_we && (mem_wdata !== d_wdata))) begin
                    n_fail++;
                    $display("FAIL rand_operands cyc=%0d got f3=%b wd=%h exp %b %h",
                             cyc, mem_func3, mem_wdata, d_func3, d_wdata);
                end
            end
            n_tests++;
            if ({if_ready, d_ready} !== {e_ir, e_dr}) begin
                n_fail++;
                $display("FAIL rand_ready cyc=%0d got if/d=%b%b exp %b%b", cyc, if_ready, d_ready, e_ir, e_dr);
            end
            n_tests++;
            if ({stall_if, stall_d} !== {if_act && !e_ir, d_act && !e_dr}) begin
                n_fail++;
                $display("FAIL rand_stall cyc=%0d got %b%b exp %b%b", cyc, stall_if, stall_d,
                         if_act && !e_ir, d_act && !e_dr);
            end
            if (e_ir) begin
                n_tests++;
                if (if_rdata !== mem_rdata) begin
                    n_fail++; $display("FAIL rand_if_rdata cyc=%0d got=%h exp=%h", cyc, if_rdata, mem_rdata);
                end
            end
            if (e_dr && !d_we) begin
                n_tests++;
                if (d_rdata !== mem_rdata) begin
                    n_fail++; $display("FAIL rand_d_rdata cyc=%0d got=%h exp=%h", cyc, d_rdata, mem_rdata);
                end
            end
            if (!if_act || winner == 1)   lost = 0;
            else if (winner == 2)         lost = (lost < LIMIT) ? lost + 1 : lost;
            if (e_ir) if_act = 1'b0;
            if (e_dr) d_act  = 1'b0;
            owner = winner;
        end
        go_idle();
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 8'h00; d_addr = 8'h00; d_wdata = 32'h0; d_func3 = 3'b000; mem_rdata = 32'h0;
        test_reset();
        test_fetch_only();
        test_contention();
        test_starvation();
        test_reset_in_resp();
        test_load_func3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
